uart_rx_deserializer: RTL

//  Serial front end of the UART RX wrapper. Samples the asynchronous rx line with a 16x tick and

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_deserializer_if.sv | 21 ++
 rtl/uart_rx_sync.sv | 52 +++++
 rtl/uart_rx_deserializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART RX serial front end: FSM state
//            encodings, status-word field positions and the word width, plus
//            a 3-input majority helper used by the input filter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_WORD_W = 12;

  // Status-word field positions; data occupies [7:0].
  localparam int FLD_OVR = 11;
  localparam int FLD_BRK = 10;
  localparam int FLD_PE  = 9;
  localparam int FLD_FE  = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WRITE     = 3'd5;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer_if
// Purpose  : Write-side connection between the RX deserializer and the RX FIFO.
// Ports    : fifo_wr_en - 1-cycle write strobe (master -> slave)
//            fifo_din   - 12-bit status+data word (master -> slave)
//            fifo_full  - FIFO full flag (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_deserializer_if;
  import uart_pkg::*;

  logic                   fifo_wr_en;
  logic [UART_WORD_W-1:0] fifo_din;
  logic                   fifo_full;

  modport master (output fifo_wr_en, output fifo_din, input fifo_full);
  modport slave  (input fifo_wr_en, input fifo_din, output fifo_full);

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Brings the asynchronous rx line into the clk domain with a 2-flop
//            synchronizer, then filters it with a majority vote over the last
//            three synchronized samples taken on baud_tick.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            baud_tick    - oversampling tick
//            rx           - raw serial input (idle high)
//            rx_s         - filtered line value
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic rx,
  output logic rx_s
);
  import uart_pkg::*;

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] hist_q,  hist_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    if (baud_tick) begin
      hist_d = {hist_q[1:0], sync2_q};
    end
  end

  // Everything resets to the idle (high) line level so that a low line at
  // reset release needs the full synchronizer + filter latency to show up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rx_s = maj3(hist_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : UART RX serial front end. Samples rx with an OVERSAMPLE x tick,
//            deserializes start/data/[parity]/stop and pushes one 12-bit word
//            {overrun, brk, parity_err, frame_err, data[7:0]} per frame into
//            the RX FIFO. Frames arriving while the FIFO is full are dropped,
//            counted, and flagged as overrun in the next written word.
// Build    : define UART_RX_PARITY_EN to expect and check a parity bit.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            baud_tick    - 1-cycle pulse at OVERSAMPLE x baud
//            rx           - asynchronous serial input, idle high
//            parity_odd   - 1 = odd, 0 = even (latched at start validation)
//            fifo         - FIFO write port (wr_en, din, full)
//            rx_busy      - frame in progress
//            drop_cnt     - saturating count of dropped frames
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic                          rx,
  input  logic                          parity_odd,
  uart_rx_deserializer_if.master        fifo,
  output logic                          rx_busy,
  output logic [7:0]                    drop_cnt
);
  import uart_pkg::*;

  localparam int             CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]  TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  logic                   rx_s;
  logic [2:0]             state_q,     state_d;
  logic [CW-1:0]          tick_cnt_q,  tick_cnt_d;
  logic [3:0]             bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic                   pe_q,        pe_d;
  logic                   fe_q,        fe_d;
  logic                   stop_zero_q, stop_zero_d;
  logic                   pend_ovr_q,  pend_ovr_d;
  logic                   wr_en_q,     wr_en_d;
  logic [UART_WORD_W-1:0] din_q,       din_d;
  logic                   busy_q,      busy_d;
  logic [7:0]             drop_q,      drop_d;
  logic                   w_sample;
  logic                   w_brk;

`ifdef UART_RX_PARITY_EN
  logic                   par_odd_q,   par_odd_d;
`else
  logic                   unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_s      (rx_s)
  );

  // Bit-centre sample point: the tick counter restarts at the start-bit
  // centre, so every OVERSAMPLE ticks afterwards lands on a bit centre.
  assign w_sample = baud_tick && (tick_cnt_q == TICK_LAST);
  assign w_brk    = (shift_q == '0) && stop_zero_q;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pe_d        = pe_q;
    fe_d        = fe_q;
    stop_zero_d = stop_zero_q;
    pend_ovr_d  = pend_ovr_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
`ifdef UART_RX_PARITY_EN
    par_odd_d   = par_odd_q;
`endif

    if (baud_tick && state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
      tick_cnt_d = w_sample ? '0 : tick_cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (baud_tick && tick_cnt_q == TICK_HALF) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            state_d     = ST_DATA;
            busy_d      = 1'b1;
            bit_cnt_d   = '0;
            pe_d        = 1'b0;
            fe_d        = 1'b0;
            stop_zero_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            par_odd_d   = parity_odd;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_sample) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_sample) begin
          pe_d    = ((^shift_q) ^ rx_s) != par_odd_q;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_sample) begin
          if (!rx_s) fe_d = 1'b1;
          else       stop_zero_d = 1'b0;
          if (bit_cnt_q == STOP_LAST) begin
            state_d = ST_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_WRITE: begin
        busy_d  = 1'b0;
        state_d = w_brk ? ST_WAIT_IDLE : ST_IDLE;
        if (!fifo.fifo_full) begin
          wr_en_d        = 1'b1;
          din_d          = '0;
          din_d[FLD_OVR] = pend_ovr_q;
          din_d[FLD_BRK] = w_brk;
          din_d[FLD_PE]  = pe_q;
          din_d[FLD_FE]  = fe_q;
          din_d[7:0]     = 8'(shift_q);
          pend_ovr_d     = 1'b0;
        end else begin
          pend_ovr_d = 1'b1;
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
      end
      ST_WAIT_IDLE: begin
        // A break holds the line low; stay silent until it is released.
        if (baud_tick && rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      stop_zero_q <= 1'b0;
      pend_ovr_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
`ifdef UART_RX_PARITY_EN
      par_odd_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      stop_zero_q <= stop_zero_d;
      pend_ovr_q  <= pend_ovr_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
`ifdef UART_RX_PARITY_EN
      par_odd_q   <= par_odd_d;
`endif
    end
  end

  assign fifo.fifo_wr_en = wr_en_q;
  assign fifo.fifo_din   = din_q;
  assign rx_busy         = busy_q;
  assign drop_cnt        = drop_q;

endmodule
`default_nettype wire
